serial_monitor: RTL and testbench
=================================

# serial_monitor

Parametrised UART-driven bootstrap monitor. It sits between the uart, the ram and the cpu, and owns the shared ram and uart ports while `monitor_control` is high. It parses 5-byte command frames (load, dump, fill, checksum, exec) and returns a status byte per command. It hands the bus to the cpu on exec and takes it back, with notification, when the cpu halts.

## Interface
- `ADDR_WIDTH`, 12: ram address width; received addresses are truncated to this width.
- `LEN_WIDTH`, 16: length counter width, 1..16; received length is truncated to this width.
- `ECHO`, 1: 1 = echo every load/fill data byte back on the uart.
- `TIMEOUT`, 24'd1200000: idle cycles between frame/data bytes before abort (100 ms at 12 MHz); 0 disables.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `rx_byte`  in  8  uart received byte
- `received`  in  1  one-cycle strobe, `rx_byte` valid
- `is_transmitting`  in  1  uart transmitter busy
- `tx_byte`  out  8  byte to send
- `transmit`  out  1  one-cycle send strobe
- `ram_waddr`, `ram_raddr`  out  ADDR_WIDTH  ram addresses
- `ram_din`  out  8  ram write data
- `ram_we`  out  1  ram write enable
- `ram_dout`  in  8  ram read data, valid 1 cycle after `ram_raddr`
- `cpu_reset`  out  1  cpu reset pulse
- `cpu_startaddr`  out  ADDR_WIDTH  cpu start address
- `cpu_halted`  in  1  cpu halt indication
- `monitor_control`  out  1  1 = monitor owns ram/uart muxes

## Operation
- Reset values: `monitor_control`=1; `transmit`, `ram_we`, `cpu_reset`=0; all address, data and `tx_byte` outputs=0; state IDLE; checksum=0.
- Frame layout: CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO. The header is always 5 bytes.
- States: IDLE, HDR, DISPATCH, LOAD, FILL_VAL, FILL, DUMP_RD, DUMP_TX, SUM_RD, SUM_ACC, ACK, RUN.
- IDLE/HDR: a 3-bit counter collects bytes; the 5th byte moves the block to DISPATCH.
- DISPATCH by CMD:
  - 0x01 LOAD: each received byte is written to addr, then addr++ and len--; optional echo.
  - 0x02 DUMP: each addr is read and its byte transmitted.
  - 0x03 EXEC: `cpu_startaddr`<=addr, `cpu_reset` 1-cycle pulse, `monitor_control`<=0, go to RUN.
  - 0x04 FILL: the next received byte V is written to len consecutive addresses, one per cycle; V is echoed once if ECHO=1.
  - 0x05 SUM: 8-bit modulo-256 sum of len bytes from addr, transmitted, then ACK.
  - Any other CMD: go to ACK with status 0xEE.
- ACK transmits a status byte, then returns to IDLE. Status values:
  - 0x00: success.
  - 0xEE: bad command.
  - 0xE7: timeout.
- len=0: no data phase. LOAD, FILL and DUMP go straight to ACK 0x00; SUM sends 0x00 then ACK.
- Address arithmetic is modulo 2^ADDR_WIDTH; a transfer past the top wraps to 0. Length decrements are saturating-free; termination is at len==0.
- RUN: the monitor drives nothing shared and ignores `received`. When `cpu_halted` is high:
  - `monitor_control`<=1 next cycle.
  - Transmit 0x48 ('H'), then go to IDLE.
- A timeout (counter reset on every `received`; counting only in HDR, LOAD and FILL_VAL) aborts to ACK 0xE7. Counting does not happen in IDLE or RUN.
- Bytes arriving during DUMP, SUM, ACK or any transmit wait are dropped.

## Timing
- Transmit handshake: `transmit` is asserted for one cycle only when `is_transmitting`=0 and the guard flag is clear.
  - The guard is set with `transmit` and cleared one cycle later, which covers the uart's 1-cycle busy latency.
  - No two strobes ever occur within 2 cycles.
- LOAD: `received` in cycle N gives `ram_we`=1 with addr/data in cycle N+1. Addr and len are updated in N+2.
- FILL: one write per cycle, len cycles. Echo/ACK follows the last write.
- DUMP/SUM: `ram_raddr` is set in cycle N; `ram_dout` is sampled in N+1. DUMP then waits for the transmit handshake.
- EXEC: `cpu_reset` high for exactly one cycle, in the same cycle `monitor_control` falls. `cpu_startaddr` is stable from that cycle.
- `cpu_halted` high in RUN gives `monitor_control`=1 the next cycle. It is ignored outside RUN.
- Asynchronous `rst` mid-transfer: everything returns to reset values immediately. A partial frame is discarded and the cpu is not reset.

## Test plan
- LOAD: 01 00 10 00 03 AA BB CC -> ram[0x010..0x012]=AA,BB,CC; uart out AA BB CC 00.
- DUMP wrap (ADDR_WIDTH=12): preload ram[0xFFF]=11 and ram[0x000]=22; send 02 0F FF 00 02 -> uart out 11 22 00.
- FILL plus SUM: 04 01 00 00 04 5A -> ram[0x100..0x103]=5A; then 05 01 00 00 04 -> uart out 68 00 (4×0x5A mod 256).
- EXEC/halt: 03 02 00 00 00 -> one-cycle `cpu_reset`, `cpu_startaddr`=0x200, `monitor_control`=0. Raise `cpu_halted` -> `monitor_control`=1 next cycle, uart out 48.
- Errors: 07 00 00 00 00 -> uart out EE. Send 01 00 (then idle for TIMEOUT cycles) -> uart out E7, state IDLE.
- Reset mid-LOAD after 1 of 3 bytes -> all outputs at reset values; a following DUMP frame works normally.

Source files
------------

// File: rtl/serial_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | serial_monitor: UART-driven bootstrap monitor (load/dump/fill/sum/exec)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_monitor #(
   parameter int          ADDR_WIDTH = 12,
   parameter int          LEN_WIDTH  = 16,
   parameter bit          ECHO       = 1'b1,
   parameter logic [23:0] TIMEOUT    = 24'd1200000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_byte,
   input  logic                  received,
   input  logic                  is_transmitting,
   output logic [7:0]            tx_byte,
   output logic                  transmit,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic [7:0]            ram_din,
   output logic                  ram_we,
   input  logic [7:0]            ram_dout,
   output logic                  cpu_reset,
   output logic [ADDR_WIDTH-1:0] cpu_startaddr,
   input  logic                  cpu_halted,
   output logic                  monitor_control
);
   typedef enum logic [3:0] {
      IDLE, HDR, DISPATCH, LOAD, LOAD_UPD, ECHO_TX, FILL_VAL, FILL,
      DUMP_RD, DUMP_TX, SUM_RD, SUM_ACC, SUM_TX, ACK, RUN, HALT_TX
   } state_t;

   localparam logic [7:0] c_ST_OK      = 8'h00;
   localparam logic [7:0] c_ST_BADCMD  = 8'hEE;
   localparam logic [7:0] c_ST_TIMEOUT = 8'hE7;
   localparam logic [7:0] c_HALT_CHAR  = 8'h48;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [7:0]            cmd_q, cmd_d, hi_q, hi_d, data_q, data_d;
   logic [7:0]            sum_q, sum_d, status_q, status_d;
   logic [7:0]            tx_byte_q, tx_byte_d, ram_din_q, ram_din_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_waddr_q, ram_waddr_d;
   logic [ADDR_WIDTH-1:0] cpu_startaddr_q, cpu_startaddr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [23:0]           tmo_q, tmo_d;
   logic                  transmit_q, transmit_d, guard_q;
   logic                  ram_we_q, ram_we_d, cpu_reset_q, cpu_reset_d, mc_q, mc_d;
   logic [15:0]           w_word;
   logic                  w_tx_ok, w_tmo_run, w_tmo_hit;

   // Guard blocks the cycle after a strobe, before the uart reports busy.
   assign w_tx_ok   = !is_transmitting && !transmit_q && !guard_q;
   assign w_word    = {hi_q, rx_byte};
   assign w_tmo_run = (TIMEOUT != 24'd0) &&
                      (state_q == HDR || state_q == LOAD || state_q == FILL_VAL);
   assign w_tmo_hit = w_tmo_run && !received && (tmo_q == TIMEOUT - 24'd1);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      cmd_d           = cmd_q;
      hi_d            = hi_q;
      data_d          = data_q;
      sum_d           = sum_q;
      status_d        = status_q;
      addr_d          = addr_q;
      len_d           = len_q;
      tx_byte_d       = tx_byte_q;
      transmit_d      = 1'b0;
      ram_waddr_d     = ram_waddr_q;
      ram_din_d       = ram_din_q;
      ram_we_d        = 1'b0;
      cpu_reset_d     = 1'b0;
      cpu_startaddr_d = cpu_startaddr_q;
      mc_d            = mc_q;
      tmo_d           = (w_tmo_run && !received) ? tmo_q + 24'd1 : 24'd0;

      case (state_q)
         IDLE: if (received) begin
            cmd_d   = rx_byte;
            cnt_d   = 3'd1;
            state_d = HDR;
         end
         HDR: if (received) begin
            cnt_d = cnt_q + 3'd1;
            case (cnt_q)
               3'd1, 3'd3: hi_d = rx_byte;
               3'd2:       addr_d = w_word[ADDR_WIDTH-1:0];
               3'd4: begin
                  len_d   = w_word[LEN_WIDTH-1:0];
                  state_d = DISPATCH;
               end
               default: ;
            endcase
         end else if (w_tmo_hit) begin
            status_d = c_ST_TIMEOUT;
            state_d  = ACK;
         end
         DISPATCH: begin
            status_d = c_ST_OK;
            case (cmd_q)
               8'h01: state_d = (len_q == '0) ? ACK : LOAD;
               8'h02: state_d = (len_q == '0) ? ACK : DUMP_RD;
               8'h03: begin
                  cpu_startaddr_d = addr_q;
                  cpu_reset_d     = 1'b1;
                  mc_d            = 1'b0;
                  state_d         = RUN;
               end
               8'h04: state_d = (len_q == '0) ? ACK : FILL_VAL;
               8'h05: begin
                  sum_d   = 8'h00;
                  state_d = (len_q == '0) ? SUM_TX : SUM_RD;
               end
               default: begin
                  status_d = c_ST_BADCMD;
                  state_d  = ACK;
               end
            endcase
         end
         LOAD: if (received) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = addr_q;
            ram_din_d   = rx_byte;
            data_d      = rx_byte;
            state_d     = LOAD_UPD;
         end else if (w_tmo_hit) begin
            status_d = c_ST_TIMEOUT;
            state_d  = ACK;
         end
         LOAD_UPD: begin
            addr_d = addr_q + 1'b1;
            len_d  = len_q - 1'b1;
            if (ECHO)
               state_d = ECHO_TX;
            else
               state_d = (len_q == LEN_WIDTH'(1)) ? ACK : LOAD;
         end
         ECHO_TX: if (w_tx_ok) begin
            tx_byte_d  = data_q;
            transmit_d = 1'b1;
            state_d    = (len_q == '0) ? ACK : LOAD;
         end
         FILL_VAL: if (received) begin
            data_d  = rx_byte;
            state_d = FILL;
         end else if (w_tmo_hit) begin
            status_d = c_ST_TIMEOUT;
            state_d  = ACK;
         end
         FILL: begin
            ram_we_d    = 1'b1;
            ram_waddr_d = addr_q;
            ram_din_d   = data_q;
            addr_d      = addr_q + 1'b1;
            len_d       = len_q - 1'b1;
            if (len_q == LEN_WIDTH'(1))
               state_d = ECHO ? ECHO_TX : ACK;
         end
         DUMP_RD: state_d = DUMP_TX;
         DUMP_TX: if (w_tx_ok) begin
            tx_byte_d  = ram_dout;
            transmit_d = 1'b1;
            addr_d     = addr_q + 1'b1;
            len_d      = len_q - 1'b1;
            state_d    = (len_q == LEN_WIDTH'(1)) ? ACK : DUMP_RD;
         end
         SUM_RD: state_d = SUM_ACC;
         SUM_ACC: begin
            sum_d   = sum_q + ram_dout;
            addr_d  = addr_q + 1'b1;
            len_d   = len_q - 1'b1;
            state_d = (len_q == LEN_WIDTH'(1)) ? SUM_TX : SUM_RD;
         end
         SUM_TX: if (w_tx_ok) begin
            tx_byte_d  = sum_q;
            transmit_d = 1'b1;
            state_d    = ACK;
         end
         ACK: if (w_tx_ok) begin
            tx_byte_d  = status_q;
            transmit_d = 1'b1;
            state_d    = IDLE;
         end
         RUN: if (cpu_halted) begin
            mc_d    = 1'b1;
            state_d = HALT_TX;
         end
         HALT_TX: if (w_tx_ok) begin
            tx_byte_d  = c_HALT_CHAR;
            transmit_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= 3'd0;
         cmd_q           <= 8'h00;
         hi_q            <= 8'h00;
         data_q          <= 8'h00;
         sum_q           <= 8'h00;
         status_q        <= 8'h00;
         addr_q          <= '0;
         len_q           <= '0;
         tmo_q           <= 24'd0;
         tx_byte_q       <= 8'h00;
         transmit_q      <= 1'b0;
         guard_q         <= 1'b0;
         ram_waddr_q     <= '0;
         ram_din_q       <= 8'h00;
         ram_we_q        <= 1'b0;
         cpu_reset_q     <= 1'b0;
         cpu_startaddr_q <= '0;
         mc_q            <= 1'b1;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         cmd_q           <= cmd_d;
         hi_q            <= hi_d;
         data_q          <= data_d;
         sum_q           <= sum_d;
         status_q        <= status_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         tmo_q           <= tmo_d;
         tx_byte_q       <= tx_byte_d;
         transmit_q      <= transmit_d;
         guard_q         <= transmit_q;
         ram_waddr_q     <= ram_waddr_d;
         ram_din_q       <= ram_din_d;
         ram_we_q        <= ram_we_d;
         cpu_reset_q     <= cpu_reset_d;
         cpu_startaddr_q <= cpu_startaddr_d;
         mc_q            <= mc_d;
      end
   end

   assign tx_byte         = tx_byte_q;
   assign transmit        = transmit_q;
   assign ram_waddr       = ram_waddr_q;
   assign ram_raddr       = addr_q;
   assign ram_din         = ram_din_q;
   assign ram_we          = ram_we_q;
   assign cpu_reset       = cpu_reset_q;
   assign cpu_startaddr   = cpu_startaddr_q;
   assign monitor_control = mc_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_serial_monitor: randomized self-checking bench with a frame-level     |
// | reference model, a behavioural ram and a uart transmitter model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_monitor;
   localparam int          AW  = 12;
   localparam logic [23:0] TMO = 24'd200;

   logic          clk = 1'b0, rst = 1'b1;
   logic [7:0]    rx_byte = 8'h00;
   logic          received = 1'b0, cpu_halted = 1'b0;
   logic          is_transmitting, transmit, ram_we, cpu_reset, monitor_control;
   logic [7:0]    tx_byte, ram_din, ram_dout;
   logic [AW-1:0] ram_waddr, ram_raddr, cpu_startaddr;

   always #5 clk = ~clk;

   serial_monitor #(.ADDR_WIDTH(AW), .LEN_WIDTH(16), .ECHO(1'b1), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
      .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
      .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout), .cpu_reset(cpu_reset), .cpu_startaddr(cpu_startaddr),
      .cpu_halted(cpu_halted), .monitor_control(monitor_control)
   );

   // behavioural synchronous ram with a bench-side preload/clear port
   logic [7:0]    mem [0:4095];
   logic          tb_clr = 1'b0, tb_we = 1'b0;
   logic [AW-1:0] tb_wa = '0;
   logic [7:0]    tb_wd = 8'h00;
   always @(posedge clk) begin
      if (tb_clr) for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      else if (tb_we) mem[tb_wa] <= tb_wd;
      else if (ram_we && monitor_control) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
   end

   // uart transmitter model: busy for a random 1..6 cycles after each strobe
   int         busy = 0, cyc = 0, last_tx = -100, min_gap = 1000, got_n = 0;
   logic [7:0] got [0:4095];
   assign is_transmitting = (busy != 0);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (transmit) begin
         got[got_n & 4095] <= tx_byte;
         got_n <= got_n + 1;
         if (cyc - last_tx < min_gap) min_gap <= cyc - last_tx;
         last_tx <= cyc;
         busy <= $urandom_range(1, 6);
      end else if (busy != 0) begin
         busy <= busy - 1;
      end
   end

   logic [7:0] exp_mem [0:4095];
   logic [7:0] pre [$];
   int         checks = 0, failures = 0, last_base = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick($urandom_range(20, 30));
      rx_byte  = b;
      received = 1'b1;
      @(negedge clk);
      received = 1'b0;
   endtask

   task automatic expect_bytes(input logic [7:0] exp[$], input int base, input string name);
      int t = 0;
      while (got_n - base < exp.size() && t < 3000) begin
         @(negedge clk);
         t++;
      end
      tick(40);
      checks++;
      if (got_n - base != exp.size()) begin
         failures++;
         $display("FAIL %s uart count: got %0d bytes, expected %0d", name, got_n - base, exp.size());
      end
      for (int i = 0; i < exp.size() && i < got_n - base; i++) begin
         checks++;
         if (got[(base + i) & 4095] !== exp[i]) begin
            failures++;
            $display("FAIL %s uart byte %0d: got %02h expected %02h", name, i, got[(base + i) & 4095], exp[i]);
         end
      end
   endtask

   task automatic check_mem(input string name);
      int bad = 0, first = -1;
      for (int i = 0; i < 4096; i++)
         if (mem[i] !== exp_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s ram: %0d bad bytes, first at %03h got %02h expected %02h",
                  name, bad, first, mem[first], exp_mem[first]);
      end
   endtask

   // Reference model of one command frame: expected uart bytes and ram image.
   task automatic do_frame(input logic [7:0] cmd, input int addr, input int len, input string name);
      logic [7:0]  exp [$];
      logic [7:0]  pl [$];
      logic [7:0]  v;
      logic [15:0] a16, l16;
      int          a, s;
      a16 = addr[15:0];
      l16 = len[15:0];
      a   = a16 % 4096;
      case (cmd)
         8'h01: begin
            for (int i = 0; i < len; i++) begin
               v = (i < pre.size()) ? pre[i] : 8'($urandom);
               pl.push_back(v);
               exp_mem[(a + i) % 4096] = v;
               exp.push_back(v);
            end
            exp.push_back(8'h00);
         end
         8'h02: begin
            for (int i = 0; i < len; i++) exp.push_back(exp_mem[(a + i) % 4096]);
            exp.push_back(8'h00);
         end
         8'h04: begin
            if (len > 0) begin
               v = (pre.size() > 0) ? pre[0] : 8'($urandom);
               pl.push_back(v);
               for (int i = 0; i < len; i++) exp_mem[(a + i) % 4096] = v;
               exp.push_back(v);
            end
            exp.push_back(8'h00);
         end
         8'h05: begin
            s = 0;
            for (int i = 0; i < len; i++) s = s + int'(exp_mem[(a + i) % 4096]);
            exp.push_back(8'(s % 256));
            exp.push_back(8'h00);
         end
         default: exp.push_back(8'hEE);
      endcase
      pre.delete();
      last_base = got_n;
      send_byte(cmd);
      send_byte(a16[15:8]);
      send_byte(a16[7:0]);
      send_byte(l16[15:8]);
      send_byte(l16[7:0]);
      foreach (pl[i]) send_byte(pl[i]);
      expect_bytes(exp, last_base, name);
      check_mem(name);
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if ({monitor_control, transmit, ram_we, cpu_reset, tx_byte, ram_waddr, ram_raddr, ram_din, cpu_startaddr}
          !== {1'b1, 3'b000, 8'h00, 12'h000, 12'h000, 8'h00, 12'h000}) begin
         failures++;
         $display("FAIL reset_values: mc=%b tx=%b we=%b cpurst=%b txb=%02h wa=%03h ra=%03h din=%02h sa=%03h expected 1 0 0 0 00 000 000 00 000",
                  monitor_control, transmit, ram_we, cpu_reset, tx_byte, ram_waddr, ram_raddr, ram_din, cpu_startaddr);
      end
      rst = 1'b0;
      tick(5);
      checks++;
      if (monitor_control !== 1'b1 || transmit !== 1'b0 || got_n != 0) begin
         failures++;
         $display("FAIL reset_idle: mc=%b transmit=%b txcount=%0d expected 1 0 0", monitor_control, transmit, got_n);
      end
   endtask

   task automatic test_load();
      pre = '{8'hAA, 8'hBB, 8'hCC};
      do_frame(8'h01, 16'h0010, 3, "load");
      checks++;
      if (mem[12'h010] !== 8'hAA || mem[12'h011] !== 8'hBB || mem[12'h012] !== 8'hCC ||
          got[(last_base + 3) & 4095] !== 8'h00) begin
         failures++;
         $display("FAIL load_literal: ram %02h %02h %02h ack %02h expected AA BB CC 00",
                  mem[12'h010], mem[12'h011], mem[12'h012], got[(last_base + 3) & 4095]);
      end
   endtask

   task automatic test_load_timing();
      logic [7:0] exp [$];
      int         base;
      base = got_n;
      send_byte(8'h01); send_byte(8'h03); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h3C);
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 12'h300 || ram_din !== 8'h3C || ram_raddr !== 12'h300) begin
         failures++;
         $display("FAIL load_timing_n1: we=%b waddr=%03h din=%02h addr=%03h expected 1 300 3C 300",
                  ram_we, ram_waddr, ram_din, ram_raddr);
      end
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || ram_raddr !== 12'h301) begin
         failures++;
         $display("FAIL load_timing_n2: we=%b addr=%03h expected 0 301", ram_we, ram_raddr);
      end
      exp_mem[12'h300] = 8'h3C;
      exp = '{8'h3C, 8'h00};
      expect_bytes(exp, base, "load_timing");
      check_mem("load_timing");
   endtask

   task automatic test_dump_wrap();
      tb_we = 1'b1; tb_wa = 12'hFFF; tb_wd = 8'h11;
      @(negedge clk);
      tb_wa = 12'h000; tb_wd = 8'h22;
      @(negedge clk);
      tb_we = 1'b0;
      exp_mem[12'hFFF] = 8'h11;
      exp_mem[12'h000] = 8'h22;
      do_frame(8'h02, 16'h0FFF, 2, "dump_wrap");
      checks++;
      if (got[last_base & 4095] !== 8'h11 || got[(last_base + 1) & 4095] !== 8'h22) begin
         failures++;
         $display("FAIL dump_wrap_literal: got %02h %02h expected 11 22",
                  got[last_base & 4095], got[(last_base + 1) & 4095]);
      end
   endtask

   task automatic test_fill_sum();
      pre = '{8'h5A};
      do_frame(8'h04, 16'h0100, 4, "fill");
      do_frame(8'h05, 16'h0100, 4, "sum");
      checks++;
      if (got[last_base & 4095] !== 8'h68 || mem[12'h103] !== 8'h5A || mem[12'h104] !== 8'h00) begin
         failures++;
         $display("FAIL fill_sum_literal: sum %02h ram103 %02h ram104 %02h expected 68 5A 00",
                  got[last_base & 4095], mem[12'h103], mem[12'h104]);
      end
      do_frame(8'h05, 16'h0100, 0, "sum_len0");
   endtask

   task automatic test_exec_halt();
      logic [7:0] exp [$];
      int         base, t;
      base = got_n;
      send_byte(8'h03); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h00);
      t = 0;
      while (cpu_reset !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (cpu_reset !== 1'b1 || monitor_control !== 1'b0 || cpu_startaddr !== 12'h200) begin
         failures++;
         $display("FAIL exec_pulse: cpu_reset=%b mc=%b startaddr=%03h expected 1 0 200",
                  cpu_reset, monitor_control, cpu_startaddr);
      end
      @(negedge clk);
      checks++;
      if (cpu_reset !== 1'b0 || monitor_control !== 1'b0 || cpu_startaddr !== 12'h200) begin
         failures++;
         $display("FAIL exec_after: cpu_reset=%b mc=%b startaddr=%03h expected 0 0 200",
                  cpu_reset, monitor_control, cpu_startaddr);
      end
      send_byte(8'h55);
      tick(20);
      checks++;
      if (got_n != base || monitor_control !== 1'b0) begin
         failures++;
         $display("FAIL run_quiet: tx bytes=%0d mc=%b expected 0 0", got_n - base, monitor_control);
      end
      cpu_halted = 1'b1;
      @(negedge clk);
      checks++;
      if (monitor_control !== 1'b1) begin
         failures++;
         $display("FAIL halt_control: mc=%b expected 1", monitor_control);
      end
      exp = '{8'h48};
      expect_bytes(exp, base, "halt_char");
      cpu_halted = 1'b0;
      check_mem("exec");
   endtask

   task automatic test_errors();
      logic [7:0] exp [$];
      int         base;
      do_frame(8'h07, 16'h0000, 0, "bad_cmd");
      checks++;
      if (got[last_base & 4095] !== 8'hEE) begin
         failures++;
         $display("FAIL bad_cmd_literal: got %02h expected EE", got[last_base & 4095]);
      end
      base = got_n;
      send_byte(8'h01);
      send_byte(8'h00);
      exp = '{8'hE7};
      expect_bytes(exp, base, "timeout");
      do_frame(8'h02, 16'h0010, 2, "after_timeout");
   endtask

   task automatic test_reset_mid_load();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h5C);
      exp_mem[12'h020] = 8'h5C;
      tick(3);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({monitor_control, transmit, ram_we, cpu_reset, tx_byte, ram_waddr, ram_raddr, ram_din, cpu_startaddr}
          !== {1'b1, 3'b000, 8'h00, 12'h000, 12'h000, 8'h00, 12'h000}) begin
         failures++;
         $display("FAIL midload_reset: mc=%b tx=%b we=%b cpurst=%b txb=%02h wa=%03h ra=%03h din=%02h sa=%03h expected 1 0 0 0 00 000 000 00 000",
                  monitor_control, transmit, ram_we, cpu_reset, tx_byte, ram_waddr, ram_raddr, ram_din, cpu_startaddr);
      end
      @(negedge clk);
      rst = 1'b0;
      tick(10);
      do_frame(8'h02, 16'h0020, 3, "dump_after_reset");
   endtask

   task automatic test_random();
      logic [7:0] cmd;
      int         r, addr, len;
      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: cmd = 8'h01;
            3, 4:    cmd = 8'h02;
            5, 6:    cmd = 8'h04;
            7, 8:    cmd = 8'h05;
            default: cmd = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         endcase
         if ($urandom_range(0, 2) == 0)
            addr = ($urandom_range(0, 15) << 12) | (4096 - $urandom_range(1, 4));
         else
            addr = $urandom_range(0, 65535);
         len = $urandom_range(0, 6);
         do_frame(cmd, addr, len, "random");
      end
   endtask

   task automatic test_tx_spacing();
      checks++;
      if (min_gap < 3) begin
         failures++;
         $display("FAIL tx_spacing: min strobe gap %0d cycles, required at least 3", min_gap);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
      tb_clr = 1'b1;
      @(negedge clk);
      tb_clr = 1'b0;
      test_reset();
      test_load();
      test_load_timing();
      test_dump_wrap();
      test_fill_sum();
      test_exec_halt();
      test_errors();
      test_reset_mid_load();
      test_random();
      test_tx_spacing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
